pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control unit for the 5-stage MIPS core: tracks in-flight instructions in a private shadow pipeline and generates per-stage write-enable, flush and forwarding-select signals. It resolves load-use and RAW data hazards, flushes wrong-path instructions after a taken branch resolved in MEM, and freezes the whole pipeline while data memory is not ready. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enable/clear inputs plus the ALU operand forwarding muxes.

## Interface
- REG_AW, 5, register-address width
- CNT_W, 16, width of saturating stall counter

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_use_rs, id_use_rt  in  1  source actually read by the ID instruction
- id_dest  in  REG_AW  ID destination (rt/rd already selected)
- id_regwrite, id_memread, id_memwrite  in  1  ID control bits
- mem_br_taken  in  1  branch AND zero of the instruction in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1  stage register enables
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble into that register
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data
- state  out  2  0 RUN, 1 DSTALL, 2 MWAIT, 3 FLUSH
- stall_cnt  out  CNT_W  cycles with pc_we=0 since reset

## Operation
- Shadow entries ex, mem, wb: {valid, rs, rt, dest, regwrite, memread, memwrite}. On a normal edge: wb<=mem, mem<=ex, ex<=ID entry (invalid if id_valid=0).
- Register 0 never creates a hazard and is never forwarded.
- Priority per cycle: memory wait > branch flush > data stall > run.
- Memory wait: mem.valid & (memread|memwrite) & !dmem_ready -> all *_we=0, no flushes, shadow holds, state MWAIT.
- Branch flush: mem_br_taken=1 -> ifid_flush=idex_flush=exmem_flush=1, all *_we=1; shadow ex and mem become invalid, wb<=mem (branch itself), state FLUSH. A concurrent data stall is discarded.
- Data stall (FORWARD_EN): ex.valid & ex.memread & ex.dest matches a used ID source -> pc_we=ifid_we=0, idex_flush=1, other we=1; shadow ex<=invalid, mem/wb advance; state DSTALL.
- Forwarding: for each EX source, if mem.valid&regwrite&dest match -> 10; else if wb.valid&regwrite&dest match -> 01; else 00. EX/MEM wins over MEM/WB.
- state is registered: the classification of the previous cycle.
- stall_cnt increments on every edge with pc_we=0, saturates at all-ones.

## Timing
- Reset (async): shadow invalid, state RUN, stall_cnt 0; while rst=1 all *_we=0, flushes 0, fwd 00. Reset mid-stall or mid-wait abandons it immediately.
- All enable/flush/fwd outputs combinational from shadow and inputs, same cycle.
- Load-use stall: exactly 1 cycle with forwarding.
- Memory wait: lasts until the cycle dmem_ready=1; that cycle is a normal advance.
- Branch flush: 1 cycle, no stall penalty beyond the 3 flushed slots.

## Configuration
- HAZARD_FORWARD_EN defined: forwarding active as above; only load-use stalls.
- Undefined: fwd_a=fwd_b=00 always; data stall whenever any valid regwrite entry in ex, mem or wb matches a used ID source (regfile not write-through, so wb counts); stall repeats until no match, up to 3 cycles.

## Test plan
- Assert rst for 2 cycles mid-stall -> state=0, stall_cnt=0, all we=0 during reset, shadow empty after.
- With HAZARD_FORWARD_EN: lw r2 then add r3,r2,r4 -> one cycle pc_we=0, idex_flush=1, state=1; next EX cycle fwd_a=01; stall_cnt=1.
- With HAZARD_FORWARD_EN: add r2,r1,r1 then sub r5,r2,r2 -> no stall, fwd_a=fwd_b=10; add r0,... then use r0 -> fwd 00.
- Without HAZARD_FORWARD_EN: add r2 then add r3,r2,r1 -> 3 stall cycles, stall_cnt=3, fwd always 00.
- mem_br_taken=1 with load-use pending in ID -> ifid/idex/exmem_flush=1, pc_we=1, state=3 next cycle, no stall.
- lw in MEM, dmem_ready=0 for 4 cycles -> all we=0 for 4 cycles, state=2, stall_cnt +4, shadow unchanged; fifth cycle advances.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: bundles the ID-stage instruction description, branch and data-memory status
// into the hazard unit, plus the stage enables, flushes, forwarding selects and status it returns.
// The master side drives the pipeline status; the hazard unit is the slave.
interface pipe_hazard_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    // Instruction currently held in ID
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;

    // Pipeline status from later stages
    logic              mem_br_taken;
    logic              dmem_ready;

    // Stage register controls
    logic              pc_we;
    logic              ifid_we;
    logic              idex_we;
    logic              exmem_we;
    logic              memwb_we;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;

    // ALU operand forwarding selects and status
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
        output id_regwrite, id_memread, id_memwrite, mem_br_taken, dmem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_flush, idex_flush, exmem_flush,
        input  fwd_a, fwd_b, state, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
        input  id_regwrite, id_memread, id_memwrite, mem_br_taken, dmem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_flush, idex_flush, exmem_flush,
        output fwd_a, fwd_b, state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard / pipeline control unit for the 5-stage MIPS core.
// Keeps a shadow copy of the EX, MEM and WB instructions and derives the stage enables,
// bubble inserts and EX operand forwarding selects from it each cycle.
// Priority: memory wait > taken-branch flush > data stall > run.
// Build option: define HAZARD_FORWARD_EN to enable operand forwarding (only load-use stalls).
// Without it, forwarding is off and ID stalls on any in-flight writer of a source register.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave bus_io
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } entry_t;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDstall = 2'd1,
        StMwait  = 2'd2,
        StFlush  = 2'd3
    } state_e;

    localparam logic [1:0] FwdNone  = 2'b00;
    localparam logic [1:0] FwdExMem = 2'b10;
    localparam logic [1:0] FwdMemWb = 2'b01;

    // Local copies of the ID-side inputs
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              br_taken;
    logic              dmem_ready;

    assign id_valid   = bus_io.id_valid;
    assign id_rs      = bus_io.id_rs;
    assign id_rt      = bus_io.id_rt;
    assign id_use_rs  = bus_io.id_use_rs;
    assign id_use_rt  = bus_io.id_use_rt;
    assign br_taken   = bus_io.mem_br_taken;
    assign dmem_ready = bus_io.dmem_ready;

    entry_t           ex_q, ex_d;
    entry_t           mem_q, mem_d;
    entry_t           wb_q, wb_d;
    entry_t           id_entry;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mem_wait;
    logic             data_hz;
    logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       fwd_a, fwd_b;

    // True when the valid ID instruction actually reads register r (r0 never counts)
    function automatic logic id_reads(input logic [REG_AW-1:0] r);
        return id_valid && (r != '0) &&
               ((id_use_rs && (id_rs == r)) || (id_use_rt && (id_rt == r)));
    endfunction

    // True when shadow entry e will write a register the ID instruction reads
    function automatic logic writes_id_src(input entry_t e);
        return e.valid && e.regwrite && id_reads(e.dest);
    endfunction

    // Select the forwarding source for one EX operand register
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input entry_t m, input entry_t w);
        logic [1:0] sel;
        sel = FwdNone;
        if (src != '0) begin
            if (m.valid && m.regwrite && (m.dest == src)) begin
                sel = FwdExMem;
            end else if (w.valid && w.regwrite && (w.dest == src)) begin
                sel = FwdMemWb;
            end
        end
        return sel;
    endfunction

    // Build the shadow entry for the instruction entering EX (bubble when ID is empty)
    always_comb begin
        id_entry = '0;
        if (id_valid) begin
            id_entry.valid    = 1'b1;
            id_entry.rs       = id_rs;
            id_entry.rt       = id_rt;
            id_entry.dest     = bus_io.id_dest;
            id_entry.regwrite = bus_io.id_regwrite;
            id_entry.memread  = bus_io.id_memread;
            id_entry.memwrite = bus_io.id_memwrite;
        end
    end

    // Data hazard detection and forwarding selects for the selected build
    always_comb begin
`ifdef HAZARD_FORWARD_EN
        // Only a load in EX cannot be forwarded in time
        data_hz = ex_q.valid && ex_q.memread && id_reads(ex_q.dest);
        fwd_a   = fwd_sel(ex_q.rs, mem_q, wb_q);
        fwd_b   = fwd_sel(ex_q.rt, mem_q, wb_q);
`else
        // Register file is not write-through, so the WB writer still blocks ID
        data_hz = writes_id_src(ex_q) || writes_id_src(mem_q) || writes_id_src(wb_q);
        fwd_a   = FwdNone;
        fwd_b   = FwdNone;
`endif
    end

    // Classify the cycle and derive stage controls plus next shadow contents
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        ex_d        = id_entry;
        mem_d       = ex_q;
        wb_d        = mem_q;
        state_d     = StRun;

        mem_wait = mem_q.valid && (mem_q.memread || mem_q.memwrite) && !dmem_ready;

        if (mem_wait) begin
            // Freeze everything, including the shadow pipeline
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
            ex_d     = ex_q;
            mem_d    = mem_q;
            wb_d     = wb_q;
            state_d  = StMwait;
        end else if (br_taken) begin
            // Branch in MEM retires; the three younger slots are wrong-path
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            ex_d        = '0;
            mem_d       = '0;
            state_d     = StFlush;
        end else if (data_hz) begin
            // Hold IF/ID, inject a bubble into EX, let the older stages drain
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            ex_d       = '0;
            state_d    = StDstall;
        end

        cnt_d = cnt_q;
        if (!pc_we && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shadow pipeline, classification and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive outputs; reset forces every control inactive regardless of inputs
    always_comb begin
        bus_io.pc_we       = pc_we && !rst;
        bus_io.ifid_we     = ifid_we && !rst;
        bus_io.idex_we     = idex_we && !rst;
        bus_io.exmem_we    = exmem_we && !rst;
        bus_io.memwb_we    = memwb_we && !rst;
        bus_io.ifid_flush  = ifid_flush && !rst;
        bus_io.idex_flush  = idex_flush && !rst;
        bus_io.exmem_flush = exmem_flush && !rst;
        bus_io.fwd_a       = rst ? FwdNone : fwd_a;
        bus_io.fwd_b       = rst ? FwdNone : fwd_b;
        bus_io.state       = state_q;
        bus_io.stall_cnt   = cnt_q;
    end

    // Not every shadow field is consumed in every build
    logic unused_shadow;
    assign unused_shadow = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl. Expected controls for each step are
// pushed to a scoreboard queue when the step is driven and popped when outputs are sampled.
// Expectations follow the HAZARD_FORWARD_EN build option the RTL is compiled with.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    pipe_hazard_if #(.REG_AW(5), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] WeRun  = 5'b11111;
    localparam logic [4:0] WeDst  = 5'b00111;
    localparam logic [4:0] WeNone = 5'b00000;
    localparam logic [2:0] FlNone = 3'b000;
    localparam logic [2:0] FlDst  = 3'b010;
    localparam logic [2:0] FlBr   = 3'b111;

    typedef struct {
        string       tag;
        logic [13:0] vec;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   base;
    int   mend;

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dest,
                          input logic rw, input logic mr, input logic mw);
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_use_rs   = urs;
        bus.id_use_rt   = urt;
        bus.id_dest     = dest;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_memwrite = mw;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expectation for the step just driven, then pop and compare after settling
    task automatic expect_out(input string tag, input logic [4:0] we, input logic [2:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                              input int cnt);
        exp_t e;
        logic [13:0] obs;
        e.tag = tag;
        e.vec = {we, fl, fa, fb, st};
        e.cnt = 16'(cnt);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        obs = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
               bus.fwd_a, bus.fwd_b, bus.state};
        checks++;
        assert (obs === e.vec) else begin
            fails++;
            $error("FAIL %s ctrl: got we/fl/fa/fb/st=%b expected %b", e.tag, obs, e.vec);
        end
        checks++;
        assert (bus.stall_cnt === e.cnt) else begin
            fails++;
            $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, bus.stall_cnt, e.cnt);
        end
    endtask

    // Three empty slots retire everything in the shadow pipeline
    task automatic drain();
        repeat (3) begin
            @(negedge clk);
            idle_id();
            bus.mem_br_taken = 1'b0;
            bus.dmem_ready   = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        idle_id();
        bus.mem_br_taken = 1'b0;
        bus.dmem_ready   = 1'b1;

        // Reset state
        @(negedge clk);
        expect_out("reset0", WeNone, FlNone, 2'b00, 2'b00, 2'd0, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef HAZARD_FORWARD_EN
        // add r2,r1,r1
        set_id(1, 5'd1, 5'd1, 1, 1, 5'd2, 1, 0, 0);
        expect_out("f_add", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // sub r5,r2,r2: no stall for an ALU producer
        @(negedge clk);
        set_id(1, 5'd2, 5'd2, 1, 1, 5'd5, 1, 0, 0);
        expect_out("f_sub", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // sub in EX takes both operands from EX/MEM
        @(negedge clk);
        idle_id();
        expect_out("f_exmem", WeRun, FlNone, 2'b10, 2'b10, 2'd0, 0);
        // add r0,r1,r1
        @(negedge clk);
        set_id(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0, 0);
        expect_out("f_add_r0", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // or r6,r0,r0
        @(negedge clk);
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0);
        expect_out("f_or_r0", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // r0 producer in MEM must not forward
        @(negedge clk);
        idle_id();
        expect_out("f_r0_nofwd", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // lw r2,0(r1)
        @(negedge clk);
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
        expect_out("f_lw", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // add r3,r2,r4: one load-use stall cycle
        @(negedge clk);
        set_id(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0, 0);
        expect_out("f_lu_stall", WeDst, FlDst, 2'b00, 2'b00, 2'd0, 0);
        @(negedge clk);
        expect_out("f_lu_go", WeRun, FlNone, 2'b00, 2'b00, 2'd1, 1);
        // add in EX gets r2 from MEM/WB
        @(negedge clk);
        idle_id();
        expect_out("f_memwb", WeRun, FlNone, 2'b01, 2'b00, 2'd0, 1);
        base = 1;
`else
        // add r2,r1,r1
        set_id(1, 5'd1, 5'd1, 1, 1, 5'd2, 1, 0, 0);
        expect_out("n_add", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // add r3,r2,r1: stalls while r2 writer is in EX, MEM and WB
        @(negedge clk);
        set_id(1, 5'd2, 5'd1, 1, 1, 5'd3, 1, 0, 0);
        expect_out("n_stall1", WeDst, FlDst, 2'b00, 2'b00, 2'd0, 0);
        @(negedge clk);
        expect_out("n_stall2", WeDst, FlDst, 2'b00, 2'b00, 2'd1, 1);
        @(negedge clk);
        expect_out("n_stall3", WeDst, FlDst, 2'b00, 2'b00, 2'd1, 2);
        @(negedge clk);
        expect_out("n_go", WeRun, FlNone, 2'b00, 2'b00, 2'd1, 3);
        base = 3;
`endif

        // Taken branch with a load-use pending in ID: flush wins, no stall
        drain();
        @(negedge clk);
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0);
        expect_out("b_lw", WeRun, FlNone, 2'b00, 2'b00, 2'd0, base);
        @(negedge clk);
        set_id(1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0);
        bus.mem_br_taken = 1'b1;
        expect_out("b_flush", WeRun, FlBr, 2'b00, 2'b00, 2'd0, base);
        @(negedge clk);
        idle_id();
        bus.mem_br_taken = 1'b0;
        expect_out("b_after", WeRun, FlNone, 2'b00, 2'b00, 2'd3, base);

        // Load in MEM waits 4 cycles for data memory
        drain();
        @(negedge clk);
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0);
        expect_out("m_lw", WeRun, FlNone, 2'b00, 2'b00, 2'd0, base);
        @(negedge clk);
        idle_id();
        expect_out("m_toex", WeRun, FlNone, 2'b00, 2'b00, 2'd0, base);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.dmem_ready = 1'b0;
            expect_out($sformatf("m_wait%0d", i), WeNone, FlNone, 2'b00, 2'b00,
                       (i == 0) ? 2'd0 : 2'd2, base + i);
        end
        // Ready: normal advance; add r10,r9,r9 shows the load was held in MEM
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        set_id(1, 5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 0);
`ifdef HAZARD_FORWARD_EN
        expect_out("m_ready", WeRun, FlNone, 2'b00, 2'b00, 2'd2, base + 4);
        @(negedge clk);
        idle_id();
        expect_out("m_fwd_wb", WeRun, FlNone, 2'b01, 2'b01, 2'd0, base + 4);
        mend = base + 4;
`else
        expect_out("m_ready", WeDst, FlDst, 2'b00, 2'b00, 2'd2, base + 4);
        @(negedge clk);
        expect_out("m_stall_wb", WeDst, FlDst, 2'b00, 2'b00, 2'd1, base + 5);
        @(negedge clk);
        expect_out("m_go", WeRun, FlNone, 2'b00, 2'b00, 2'd1, base + 6);
        mend = base + 6;
`endif

        // Reset in the middle of a memory wait
        drain();
        @(negedge clk);
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd11, 1, 1, 0);
        expect_out("r_lw", WeRun, FlNone, 2'b00, 2'b00, 2'd0, mend);
        @(negedge clk);
        idle_id();
        expect_out("r_toex", WeRun, FlNone, 2'b00, 2'b00, 2'd0, mend);
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        expect_out("r_wait", WeNone, FlNone, 2'b00, 2'b00, 2'd0, mend);
        @(negedge clk);
        rst = 1'b1;
        expect_out("r_rst1", WeNone, FlNone, 2'b00, 2'b00, 2'd0, 0);
        @(negedge clk);
        expect_out("r_rst2", WeNone, FlNone, 2'b00, 2'b00, 2'd0, 0);
        // Shadow is empty afterwards, so dmem_ready=0 no longer holds the pipe
        @(negedge clk);
        rst = 1'b0;
        expect_out("r_post", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        expect_out("r_post2", WeRun, FlNone, 2'b00, 2'b00, 2'd0, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
